i2s_tx: RTL and testbench

Audio serial transmitter for the external DAC. It derives MCLK, SCLK and LRCK from the 100 MHz system clock using a single free-running frame counter, and serializes 24-bit stereo samples in I2S format. Samples arrive through a one-entry valid/ready buffer and are committed once per frame. It sits between the synthesizer mixer (upstream) and the DAC pins (downstream).

---
 rtl/i2s_tx.sv | 109 ++++++++++
 tb/tb_i2s_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S stereo DAC transmitter: MCLK/SCLK/LRCK come from one free-running frame counter.
// Samples pass through a one-entry buffer. Define I2S_TX_LJ_EN for left-justified framing.
module i2s_tx #(
  parameter int MCLK_LOG2 = 3,
  parameter int SAMPLE_W  = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);
  localparam int M  = MCLK_LOG2;
  localparam int CW = MCLK_LOG2 + 8;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_valid_q;
  logic [SAMPLE_W-1:0] pend_l_q, pend_r_q;
  logic [SAMPLE_W-1:0] act_l_q, act_r_q, act_l_d, act_r_d;
  logic [15:0]         underrun_cnt_q, underrun_cnt_d;
  logic                mclk_q, sclk_q, lrck_q, sdata_q, frame_start_q, underrun_q;
  logic                boundary, accept, lrck_d, sdata_d;
  logic [5:0]          slot_d;
  logic [SAMPLE_W-1:0] word_d;
  logic [31:0]         chan_d;

  assign in_ready = !pend_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign boundary = (cnt_q == '1);

  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    act_l_d        = act_l_q;
    act_r_d        = act_r_q;
    underrun_cnt_d = underrun_cnt_q;
    if (boundary) begin
      if (pend_valid_q) begin
        act_l_d = pend_l_q;
        act_r_d = pend_r_q;
      end else begin
        act_l_d = '0;
        act_r_d = '0;
        if (underrun_cnt_q != '1) underrun_cnt_d = underrun_cnt_q + 1'b1;
      end
    end
    slot_d = cnt_d[M+7:M+2];
    word_d = slot_d[5] ? act_r_d : act_l_d;
    // Align the channel word in a 32-slot vector so slot s reads bit 31-s.
`ifdef I2S_TX_LJ_EN
    chan_d = 32'(word_d) << (32 - SAMPLE_W);
    lrck_d = ~cnt_d[M+7];
`else
    chan_d = 32'(word_d) << (31 - SAMPLE_W);
    lrck_d = cnt_d[M+7];
`endif
    sdata_d = chan_d[~slot_d[4:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      pend_valid_q   <= 1'b0;
      pend_l_q       <= '0;
      pend_r_q       <= '0;
      act_l_q        <= '0;
      act_r_q        <= '0;
      underrun_cnt_q <= '0;
      mclk_q         <= 1'b0;
      sclk_q         <= 1'b0;
      lrck_q         <= 1'b0;
      sdata_q        <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      act_l_q        <= act_l_d;
      act_r_q        <= act_r_d;
      underrun_cnt_q <= underrun_cnt_d;
      mclk_q         <= cnt_d[M-1];
      sclk_q         <= cnt_d[M+1];
      lrck_q         <= lrck_d;
      sdata_q        <= sdata_d;
      frame_start_q  <= (cnt_d == '0);
      underrun_q     <= boundary && !pend_valid_q;
      if (boundary) pend_valid_q <= 1'b0;
      if (accept) begin
        pend_valid_q <= 1'b1;
        pend_l_q     <= in_left;
        pend_r_q     <= in_right;
      end
    end
  end

  assign mclk         = mclk_q;
  assign sclk         = sclk_q;
  assign lrck         = lrck_q;
  assign sdata        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: buffer model + frame scoreboard, vector table, corner sequences.
module tb_i2s_tx;
  localparam int M  = 3;
  localparam int SW = 24;
  localparam int FR = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [SW-1:0] in_left = '0;
  logic [SW-1:0] in_right = '0;
  logic          in_ready, mclk, sclk, lrck, sdata, frame_start, underrun;
  logic [15:0]   underrun_cnt;

  always #5 clk = ~clk;

  i2s_tx #(.MCLK_LOG2(M), .SAMPLE_W(SW)) dut (
    .clk(clk), .rst(rst), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .mclk(mclk), .sclk(sclk),
    .lrck(lrck), .sdata(sdata), .frame_start(frame_start),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [10:0]     cyc = '0;
  logic            prev_rst = 1'b1;
  logic            armed = 1'b0;
  logic            pend_m = 1'b0;
  logic [2*SW-1:0] pend_pair = '0;
  logic [2*SW-1:0] cur = '0;
  logic            exp_under = 1'b0;
  logic [15:0]     ucnt_m = '0;
  logic            poke = 1'b0;
  int unsigned     acc_cnt = 0;
  int unsigned     under_seen = 0;
  logic [2*SW-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cyc %0d)", name, cyc);
  endtask

  function automatic logic exp_bit(input logic [2*SW-1:0] p, input logic [5:0] slot);
    logic [63:0] fv;
    logic [5:0]  idx;
`ifdef I2S_TX_LJ_EN
    fv = {p[47:24], 8'h00, p[23:0], 8'h00};
`else
    fv = {1'b0, p[47:24], 7'h00, 1'b0, p[23:0], 7'h00};
`endif
    idx = 6'd63 - slot;
    return fv[idx];
  endfunction

  // Buffer / frame model; pushes the expected content of each upcoming frame.
  always @(posedge clk) begin
    prev_rst <= rst;
    armed    <= armed | rst;
    if (rst) begin
      cyc       <= '0;
      pend_m    <= 1'b0;
      ucnt_m    <= '0;
      exp_under <= 1'b0;
      sb.delete();
      sb.push_back('0);
    end else begin
      cyc       <= cyc + 1'b1;
      exp_under <= 1'b0;
      if (cyc == 11'h7FF) begin
        if (pend_m) begin
          sb.push_back(pend_pair);
          pend_m <= 1'b0;
        end else begin
          sb.push_back('0);
          exp_under <= 1'b1;
          if (ucnt_m != 16'hFFFF) ucnt_m <= ucnt_m + 1'b1;
        end
      end
      if (in_valid && !pend_m) begin
        pend_m    <= 1'b1;
        pend_pair <= {in_left, in_right};
      end
      if (in_valid && in_ready) acc_cnt++;
      if (poke) ucnt_m <= 16'hFFFE;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (!rst && cyc == 11'd0) begin
        if (sb.size() == 0) begin
          timeout("sb_empty");
          cur = '0;
        end else begin
          cur = sb.pop_front();
        end
      end
      check("in_ready", in_ready, !rst && !pend_m);
      if (prev_rst) begin
        check("rst_outs", {mclk, sclk, lrck, sdata, frame_start, underrun}, 0);
        check("rst_ucnt", underrun_cnt, 0);
      end else begin
        check("mclk", mclk, cyc[M-1]);
        check("sclk", sclk, cyc[M+1]);
`ifdef I2S_TX_LJ_EN
        check("lrck", lrck, ~cyc[M+7]);
`else
        check("lrck", lrck, cyc[M+7]);
`endif
        check("frame_start", frame_start, cyc == 11'd0);
        check("underrun", underrun, exp_under);
        check("underrun_cnt", underrun_cnt, poke ? 16'hFFFE : ucnt_m);
        check("sdata", sdata, exp_bit(cur, cyc[M+7:M+2]));
      end
      if (underrun) under_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input logic [10:0] target);
    int unsigned n = 0;
    while (cyc != target && n < 3*FR) begin
      tick();
      n++;
    end
    if (cyc != target) timeout("wait_cyc");
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int unsigned n = 0;
    int unsigned a;
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    a = acc_cnt;
    while (acc_cnt == a && n < 3*FR) begin
      tick();
      n++;
    end
    if (acc_cnt == a) timeout("send");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (pend_m && n < 3*FR) begin
      tick();
      n++;
    end
    if (pend_m) timeout("drain");
  endtask

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic [10:0]   pos;
    int unsigned   under;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int unsigned exp_u;
    int unsigned a0;
    vecs[0] = '{l: 24'h800001, r: 24'h7FFFFF, pos: 11'd100,  under: 0};
    vecs[1] = '{l: 24'h123456, r: 24'hFEDCBA, pos: 11'd1500, under: 0};
    vecs[2] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, pos: 11'd2047, under: 1};
    vecs[3] = '{l: 24'h000001, r: 24'hFFFFFF, pos: 11'd0,    under: 0};
    vecs[4] = '{l: 24'hFFFFFF, r: 24'h000000, pos: 11'd2000, under: 0};
    vecs[5] = '{l: 24'h800000, r: 24'h000001, pos: 11'd300,  under: 0};

    rst = 1'b1;
    repeat (4) tick();
    check("rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);

    repeat (3) begin
      wait_cyc(11'd2047);
      tick();
    end
    tick();
    check("idle_pulses", under_seen, 3);
    check("idle_ucnt", underrun_cnt, 3);
    exp_u = 3;

    for (int unsigned i = 0; i < 6; i++) begin
      wait_cyc(vecs[i].pos);
      send(vecs[i].l, vecs[i].r);
      wait_drain();
      exp_u += vecs[i].under;
      check("vec_ucnt", underrun_cnt, exp_u);
    end

    a0 = acc_cnt;
    in_left  = 24'h000100;
    in_right = 24'hFFF000;
    in_valid = 1'b1;
    for (int unsigned k = 0; k < 4*FR; k++) begin
      int unsigned a;
      a = acc_cnt;
      tick();
      if (acc_cnt != a) begin
        in_left  = in_left + 1'b1;
        in_right = in_right - 1'b1;
      end
    end
    in_valid = 1'b0;
    check("stream_accepts", acc_cnt - a0, 4);
    check("stream_ucnt", underrun_cnt, exp_u);

    repeat (5) tick();
    force dut.underrun_cnt_q = 16'hFFFE;
    poke = 1'b1;
    tick();
    release dut.underrun_cnt_q;
    poke = 1'b0;
    wait_cyc(11'd2047);
    tick();
    tick();
    check("sat_reach", underrun_cnt, 16'hFFFF);
    wait_cyc(11'd2047);
    tick();
    check("sat_pulse", underrun, 1);
    tick();
    check("sat_hold", underrun_cnt, 16'hFFFF);

    wait_cyc(11'd200);
    send(24'h13579B, 24'h2468AC);
    wait_cyc(11'd1290);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_outs", {mclk, sclk, lrck, sdata, frame_start, underrun}, 0);
    check("midrst_ucnt", underrun_cnt, 0);
    check("midrst_ready", in_ready, 1);
    wait_cyc(11'd2047);
    tick();
    check("post_rst_under", underrun, 1);
    tick();
    check("post_rst_ucnt", underrun_cnt, 1);

    repeat (10) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
